// File: rtl/prom_fetch.sv
// Boot-ROM backed microcode PROM: on a tag miss, reads seven bytes from a byte-wide ROM
// and assembles them into a 49-bit microinstruction word, with a single-entry tag cache.
module prom_fetch #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        promce,
  input  logic [8:0]  promaddr,
  output logic [11:0] rom_addr,
  output logic        rom_rd,
  input  logic        rom_ack,
  input  logic [7:0]  rom_data,
  output logic [48:0] iprom,
  output logic        iprom_valid,
  output logic        busy,
  output logic        fault
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD    = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] LAST_IDX = 3'd6;

  logic [1:0]  state_q, state_d;
  logic [8:0]  waddr_q, waddr_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [47:0] shadow_q, shadow_d;
  logic [48:0] iprom_q, iprom_d;
  logic        ipv_q, ipv_d;
  logic [8:0]  tag_q, tag_d;
  logic        tagv_q, tagv_d;
  logic [11:0] rom_addr_q, rom_addr_d;
  logic        fault_q, fault_d;
  logic        hit_s;

  assign hit_s = promce & tagv_q & (promaddr == tag_q);

  // Next-state and datapath decode for the fetch sequencer.
  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    idx_d      = idx_q;
    tmo_d      = tmo_q;
    shadow_d   = shadow_q;
    iprom_d    = iprom_q;
    ipv_d      = ipv_q;
    tag_d      = tag_q;
    tagv_d     = tagv_q;
    rom_addr_d = rom_addr_q;
    fault_d    = fault_q;
    case (state_q)
      S_IDLE: begin
        if (promce && !hit_s) begin
          waddr_d    = promaddr;
          idx_d      = 3'd0;
          tmo_d      = 8'd0;
          ipv_d      = 1'b0;
          rom_addr_d = {promaddr, 3'd0};
          state_d    = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (rom_ack) begin
          tmo_d = 8'd0;
          if (idx_q < LAST_IDX) begin
            shadow_d[int'(idx_q) * 8 +: 8] = rom_data;
            idx_d   = idx_q + 3'd1;
            state_d = S_GAP;
          end else begin
            // Only bit 0 of the seventh byte belongs to the 49-bit word.
            iprom_d = {rom_data[0], shadow_q};
            tag_d   = waddr_q;
            tagv_d  = 1'b1;
            ipv_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tmo_q == TMO_LAST) begin
          fault_d = 1'b1;
          ipv_d   = 1'b0;
          tagv_d  = 1'b0;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_GAP: begin
        // Address advances only as the strobe reasserts, so it is stable while rom_rd is low.
        rom_addr_d = {waddr_q, idx_q};
        tmo_d      = 8'd0;
        state_d    = S_RD;
      end
      S_FAULT: begin
        if (!promce) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_FAULT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      waddr_q    <= 9'd0;
      idx_q      <= 3'd0;
      tmo_q      <= 8'd0;
      shadow_q   <= 48'd0;
      iprom_q    <= 49'd0;
      ipv_q      <= 1'b0;
      tag_q      <= 9'd0;
      tagv_q     <= 1'b0;
      rom_addr_q <= 12'd0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      waddr_q    <= waddr_d;
      idx_q      <= idx_d;
      tmo_q      <= tmo_d;
      shadow_q   <= shadow_d;
      iprom_q    <= iprom_d;
      ipv_q      <= ipv_d;
      tag_q      <= tag_d;
      tagv_q     <= tagv_d;
      rom_addr_q <= rom_addr_d;
      fault_q    <= fault_d;
    end
  end

  assign rom_rd      = (state_q == S_RD);
  assign busy        = (state_q == S_RD) | (state_q == S_GAP);
  assign rom_addr    = rom_addr_q;
  assign iprom       = iprom_q;
  assign iprom_valid = ipv_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_prom_fetch.sv
// Scoreboard bench for prom_fetch: a ROM responder with random wait states, a reference
// model that predicts whole fetch results, and a monitor that checks them as they appear.
module tb_prom_fetch;

  localparam int unsigned TMO = 4;

  logic        clk;
  logic        reset;
  logic        promce;
  logic [8:0]  promaddr;
  logic [11:0] rom_addr;
  logic        rom_rd;
  logic        rom_ack;
  logic [7:0]  rom_data;
  logic [48:0] iprom;
  logic        iprom_valid;
  logic        busy;
  logic        fault;

  prom_fetch #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .promce(promce), .promaddr(promaddr),
    .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_ack(rom_ack), .rom_data(rom_data),
    .iprom(iprom), .iprom_valid(iprom_valid), .busy(busy), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 = completed fetch, 1 = timeout fault
    logic [8:0]  addr;
    logic [48:0] word;
    int          lat;
  } ev_t;

  typedef struct {
    int          id;
    logic [48:0] word;
    logic        ipv;
    logic        bsy;
    logic        flt;
    logic        rd;
    logic        chk_addr;
    logic [11:0] addr;
  } st_t;

  ev_t  ev_q[$];
  st_t  st_q[$];
  int   w_q[$];
  logic [7:0] mem [0:4095];

  int n_cmp;
  int n_fail;

  logic [8:0]  m_tag;
  logic        m_tagv;
  logic [48:0] m_iprom;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [48:0] rom_word(input logic [8:0] a);
    logic [48:0] w;
    w = 49'd0;
    for (int i = 0; i < 6; i++) w[8*i +: 8] = mem[{a, 3'(i)}];
    w[48] = mem[{a, 3'd6}][0];
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input int id, input logic [48:0] word, input logic ipv, input logic bsy,
                         input logic flt, input logic rd, input logic ca, input logic [11:0] addr);
    st_q.push_back('{id, word, ipv, bsy, flt, rd, ca, addr});
  endtask

  // Request a word that the model predicts to be a miss; waits per byte drawn from [wlo,whi].
  task automatic issue(input logic [8:0] a, input int wlo, input int whi);
    int lat;
    int w;
    lat = 7;
    for (int i = 0; i < 7; i++) begin
      w = $urandom_range(whi, wlo);
      w_q.push_back(w);
      lat += w + 1;
    end
    ev_q.push_back('{0, a, rom_word(a), lat});
    m_tag    = a;
    m_tagv   = 1'b1;
    m_iprom  = rom_word(a);
    promaddr = a;
    promce   = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!busy && n < 8) begin step(); n++; end
    if (!busy) bound_fail({name, "_start"});
    n = 0;
    while (busy && n < 400) begin step(); n++; end
    if (busy) bound_fail({name, "_end"});
  endtask

  task automatic hit_check(input logic [8:0] a, input int cycles);
    promaddr = a;
    promce   = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      push_st(10, m_iprom, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
      step();
    end
  endtask

  task automatic run_stim();
    logic [8:0] a;
    logic [8:0] old;
    int n;
    reset = 1'b1;
    promce = 1'b0;
    promaddr = 9'd0;
    m_tag = 9'd0;
    m_tagv = 1'b0;
    m_iprom = 49'd0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 7; i++) mem[12'h028 + i] = 8'(8'h11 * (i + 1));
    step();
    push_st(0, 49'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0);
    step();
    reset = 1'b0;
    step();

    // Cold miss with ack tied high, then repeated hits.
    issue(9'h005, 0, 0);
    wait_idle("cold");
    hit_check(9'h005, 4);
    promce = 1'b0;
    step();
    hit_check(9'h005, 2);

    // Address change during byte 3 of a fetch.
    issue(9'h010, 0, 2);
    wait_idle("pre");
    issue(9'h005, 0, 1);
    n = 0;
    while (!(rom_rd && rom_addr == 12'h02B) && n < 100) begin step(); n++; end
    if (n >= 100) bound_fail("byte3");
    issue(9'h006, 0, 0);
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    if (busy) bound_fail("first_done");
    step();
    push_st(1, rom_word(9'h005), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h030);
    wait_idle("refetch6");

    // Three wait states per byte.
    issue(9'h005, 3, 3);
    wait_idle("waits");

    // Random mix of hits and misses.
    for (int k = 0; k < 10; k++) begin
      a = ($urandom_range(3, 0) == 0 && m_tagv) ? m_tag : 9'($urandom);
      if (m_tagv && a == m_tag) hit_check(a, 3);
      else begin
        issue(a, 0, 3);
        wait_idle("rand");
      end
      if ($urandom_range(1, 0) == 1) begin promce = 1'b0; step(); end
    end

    // Timeout with no ack at all.
    old = m_tag;
    a = m_tag ^ 9'h100;
    w_q.push_back(1000);
    ev_q.push_back('{1, a, m_iprom, TMO});
    m_tagv = 1'b0;
    promaddr = a;
    promce = 1'b1;
    wait_idle("timeout");
    push_st(2, m_iprom, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
    step();
    push_st(3, m_iprom, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0);
    promce = 1'b0;
    step();
    push_st(4, m_iprom, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
    step();
    issue(old, 0, 0);
    wait_idle("after_fault");

    // Reset in the middle of byte 2.
    a = m_tag ^ 9'h0F0;
    issue(a, 0, 1);
    n = 0;
    while (!(rom_rd && rom_addr[2:0] == 3'd2) && n < 100) begin step(); n++; end
    if (n >= 100) bound_fail("byte2");
    reset = 1'b1;
    #1;
    ev_q.delete();
    w_q.delete();
    m_tagv = 1'b0;
    m_iprom = 49'd0;
    push_st(5, 49'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 12'd0);
    step();
    issue(a, 0, 0);
    step();
    reset = 1'b0;
    step();
    push_st(6, 49'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, {a, 3'd0});
    wait_idle("after_reset");
    repeat (3) step();
    chk("ev_queue_drained", 64'(ev_q.size()), 64'd0);
    chk("st_queue_drained", 64'(st_q.size()), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rom_ack = 1'b0;
    rom_data = 8'd0;
    fork
      run_stim();
      begin : monitor
        logic prev_ipv, prev_flt, prev_bsy, prev_rd;
        logic [48:0] prev_iprom;
        logic [11:0] prev_addr;
        logic [11:0] seq [0:6];
        int cyc, c_busy, n_rd, n_strobe;
        ev_t e;
        st_t s;
        prev_ipv = 1'b0; prev_flt = 1'b0; prev_bsy = 1'b0; prev_rd = 1'b0;
        prev_iprom = 49'd0; prev_addr = 12'd0;
        cyc = 0; c_busy = 0; n_rd = 0; n_strobe = 0;
        forever begin
          @(negedge clk);
          cyc++;
          if (reset) begin n_rd = 0; n_strobe = 0; end
          if (busy && !prev_bsy) begin c_busy = cyc; n_rd = 0; n_strobe = 0; end
          if (rom_rd) n_rd++;
          if (rom_rd && !prev_rd) begin
            if (n_strobe < 7) seq[n_strobe] = rom_addr;
            n_strobe++;
          end
          if (!reset && !rom_rd && rom_addr !== prev_addr)
            chk("rom_addr_hold", 64'(rom_addr), 64'(prev_addr));
          if (!reset && iprom !== prev_iprom && !(iprom_valid && !prev_ipv))
            chk("iprom_stable", 64'(iprom), 64'(prev_iprom));
          if (iprom_valid && !prev_ipv) begin
            if (ev_q.size() == 0) bound_fail("unexpected_valid");
            else begin
              e = ev_q.pop_front();
              chk("ev_kind_fetch", 64'(e.kind), 64'd0);
              chk("iprom", 64'(iprom), 64'(e.word));
              chk("latency", 64'(cyc - c_busy + 1), 64'(e.lat));
              chk("strobes", 64'(n_strobe), 64'd7);
              for (int i = 0; i < 7; i++)
                chk($sformatf("rom_addr_b%0d", i), 64'(seq[i]), 64'({e.addr, 3'(i)}));
            end
          end
          if (fault && !prev_flt) begin
            if (ev_q.size() == 0) bound_fail("unexpected_fault");
            else begin
              e = ev_q.pop_front();
              chk("ev_kind_fault", 64'(e.kind), 64'd1);
              chk("fault_iprom", 64'(iprom), 64'(e.word));
              chk("fault_valid", 64'(iprom_valid), 64'd0);
              chk("fault_rd_cycles", 64'(n_rd), 64'(e.lat));
              chk("fault_busy", 64'(busy), 64'd0);
            end
          end
          while (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk($sformatf("st%0d_iprom", s.id), 64'(iprom), 64'(s.word));
            chk($sformatf("st%0d_valid", s.id), 64'(iprom_valid), 64'(s.ipv));
            chk($sformatf("st%0d_busy", s.id), 64'(busy), 64'(s.bsy));
            chk($sformatf("st%0d_fault", s.id), 64'(fault), 64'(s.flt));
            chk($sformatf("st%0d_rd", s.id), 64'(rom_rd), 64'(s.rd));
            if (s.chk_addr) chk($sformatf("st%0d_addr", s.id), 64'(rom_addr), 64'(s.addr));
          end
          prev_ipv = iprom_valid; prev_flt = fault; prev_bsy = busy; prev_rd = rom_rd;
          prev_iprom = iprom; prev_addr = rom_addr;
        end
      end
      begin : responder
        logic act;
        int cnt, wt;
        act = 1'b0; cnt = 0; wt = 0;
        forever begin
          @(posedge clk);
          #1;
          if (rom_rd) begin
            if (!act) begin
              act = 1'b1;
              cnt = 0;
              wt = (w_q.size() > 0) ? w_q.pop_front() : 0;
            end else begin
              cnt++;
            end
            rom_ack  = (cnt == wt);
            rom_data = rom_ack ? mem[rom_addr] : 8'($urandom);
          end else begin
            act      = 1'b0;
            rom_ack  = 1'($urandom);
            rom_data = 8'($urandom);
          end
        end
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
